// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/done handshake and operand/result bus for booth_multiplier_seq.
//   start, multiplicand, multiplier : control unit -> multiplier
//   busy, done, product_hi, product_lo : multiplier -> control unit
// Modports: master = control unit side, slave = multiplier side.
interface booth_multiplier_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product_hi,
    input  product_lo
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product_hi,
    output product_lo
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Multi-cycle signed two's-complement multiplier (Booth-recoded shift-add) for the
// MUL instruction. Produces a 2*WIDTH-bit product split into HI/LO halves.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous, active-high reset; discards any in-flight operation
//   bus   : booth_multiplier_seq_if.slave
//           start (sampled only when idle), multiplicand/multiplier (latched on accept),
//           busy (high while running), done (one-cycle pulse), product_hi/product_lo
//           (held until the next completion or reset)
// Parameter:
//   WIDTH : operand width, even and >= 4
// Build option:
//   MUL_RADIX4_EN : when defined, radix-4 bit-pair recoding (WIDTH/2 steps);
//                   otherwise radix-2 Booth (WIDTH steps). Results are identical.
module booth_multiplier_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  booth_multiplier_seq_if.slave       bus
);

`ifdef MUL_RADIX4_EN
  localparam int unsigned AW = WIDTH + 2;   // room for +-2M with M = -2^(WIDTH-1)
  localparam int unsigned N  = WIDTH / 2;
`else
  localparam int unsigned AW = WIDTH + 1;   // room for -M with M = -2^(WIDTH-1)
  localparam int unsigned N  = WIDTH;
`endif
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_a;
  logic [AW-1:0]    r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [AW-1:0]    w_neg_m;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_qm1_nxt;

  assign w_neg_m = AW'(0) - r_m;

`ifdef MUL_RADIX4_EN
  logic [AW-1:0] w_m2;
  logic [AW-1:0] w_neg_m2;

  assign w_m2     = {r_m[AW-2:0], 1'b0};
  assign w_neg_m2 = AW'(0) - w_m2;

  // Bit-pair recoding of {Q[1],Q[0],Q[-1]}, then arithmetic shift right by 2.
  always_comb begin
    w_addend = '0;
    case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_addend = r_m;
      3'b011:         w_addend = w_m2;
      3'b100:         w_addend = w_neg_m2;
      3'b101, 3'b110: w_addend = w_neg_m;
      default:        w_addend = '0;
    endcase
    w_sum     = r_a + w_addend;
    w_a_nxt   = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    w_q_nxt   = {w_sum[1:0], r_q[WIDTH-1:2]};
    w_qm1_nxt = r_q[1];
  end
`else
  // Radix-2 recoding of {Q[0],Q[-1]}, then arithmetic shift right by 1.
  always_comb begin
    w_addend = '0;
    case ({r_q[0], r_qm1})
      2'b01:   w_addend = r_m;
      2'b10:   w_addend = w_neg_m;
      default: w_addend = '0;
    endcase
    w_sum     = r_a + w_addend;
    w_a_nxt   = {w_sum[AW-1], w_sum[AW-1:1]};
    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    w_qm1_nxt = r_q[0];
  end
`endif

  // Control FSM and datapath registers; done is a registered one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= {{(AW-WIDTH){bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            r_q     <= bus.multiplier;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            // After the final shift {A[WIDTH-1:0], Q} is the exact product.
            r_hi    <= w_a_nxt[WIDTH-1:0];
            r_lo    <= w_q_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.product_hi = r_hi;
  assign bus.product_lo = r_lo;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed self-checking bench for booth_multiplier_seq (both radix builds).
module tb_booth_multiplier_seq;
  localparam int unsigned WIDTH = 32;
`ifdef MUL_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_multiplier_seq_if #(.WIDTH(WIDTH)) bus ();

  booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle; returns at the negedge after acceptance.
  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.start        = 1'b0;
  endtask

  // Called at the negedge after the accepting edge. mode 1 scrambles operands
  // mid-op, mode 2 pulses start (2x2) while busy. chain starts 2x2 in the done cycle.
  task automatic wait_result(input string tag, input logic [63:0] exp_prod,
                             input int mode, input bit chain);
    int busy_cnt;
    int early_done;
    busy_cnt   = bus.busy ? 1 : 0;
    early_done = bus.done ? 1 : 0;
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) early_done++;
      if (mode == 1 && i == 3) begin
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end
      if (mode == 2 && i == 5) begin
        bus.start        = 1'b1;
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd2;
      end
      if (mode == 2 && i == 6) bus.start = 1'b0;
    end
    @(negedge clk);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(N));
    check({tag, " early_done"}, 64'(early_done), 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " product"}, {bus.product_hi, bus.product_lo}, exp_prod);
    if (chain) begin
      bus.start        = 1'b1;
      bus.multiplicand = 32'd2;
      bus.multiplier   = 32'd2;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " done_pulse_end"}, 64'(bus.done), 64'd0);
    check({tag, " busy_after"}, 64'(bus.busy), chain ? 64'd1 : 64'd0);
    if (!chain)
      check({tag, " product_hold"}, {bus.product_hi, bus.product_lo}, exp_prod);
  endtask

  initial begin
    int done_seen;
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset product", {bus.product_hi, bus.product_lo}, 64'd0);
    rst = 1'b0;

    // 1: small positive
    start_op(32'd6, 32'd7);
    wait_result("6x7", 64'h00000000_0000002A, 0, 1'b0);

    // 2: negative multiplicand
    start_op(32'hFFFFFFFD, 32'd5);
    wait_result("-3x5", 64'hFFFFFFFF_FFFFFFF1, 0, 1'b0);

    // 3: most negative squared
    start_op(32'h80000000, 32'h80000000);
    wait_result("minxmin", 64'h40000000_00000000, 0, 1'b0);

    // Most negative times -1, and zero operand (constant latency)
    start_op(32'h80000000, 32'hFFFFFFFF);
    wait_result("minxm1", 64'h00000000_80000000, 0, 1'b0);
    start_op(32'd0, 32'h12345678);
    wait_result("0xq", 64'h00000000_00000000, 0, 1'b0);

    // 4: operands scrambled while busy
    start_op(32'hFFFFFFFF, 32'h7FFFFFFF);
    wait_result("m1xmax", 64'hFFFFFFFF_80000001, 1, 1'b0);

    // 5: start while busy is ignored; start in the done cycle is accepted
    start_op(32'd6, 32'd7);
    wait_result("6x7_poke", 64'h00000000_0000002A, 2, 1'b1);
    wait_result("2x2_chain", 64'h00000000_00000004, 0, 1'b0);

    // 6: reset mid-operation
    start_op(32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst product", {bus.product_hi, bus.product_lo}, 64'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("midrst no_done", 64'(done_seen), 64'd0);
    start_op(32'hFFFFFFF9, 32'd123);
    wait_result("after_rst", 64'hFFFFFFFF_FFFFFCA3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
